// File: rtl/write_back_if.sv
// rtl/write_back_if.sv - MEM/WB pipeline register bus into the write-back stage and its WB forwarding slot
interface write_back_if;
  logic        keep;
  logic        RegWrite_pype3;
  logic [1:0]  MemtoReg_pype3;
  logic [4:0]  WReg_pype3;
  logic [31:0] ALU_co_pype3;
  logic [31:0] PCp4_pype3;
  logic [31:0] mem_data_pype;
  logic [31:0] Instraction_pype3;
  logic [31:0] WB_data_pype4;
  logic [4:0]  WReg_pype4;
  logic        RegWrite_pype4;

  modport master (
    output keep, RegWrite_pype3, MemtoReg_pype3, WReg_pype3, ALU_co_pype3,
           PCp4_pype3, mem_data_pype, Instraction_pype3,
    input  WB_data_pype4, WReg_pype4, RegWrite_pype4
  );

  modport slave (
    input  keep, RegWrite_pype3, MemtoReg_pype3, WReg_pype3, ALU_co_pype3,
           PCp4_pype3, mem_data_pype, Instraction_pype3,
    output WB_data_pype4, WReg_pype4, RegWrite_pype4
  );
endinterface

// File: rtl/write_back.sv
// rtl/write_back.sv - write-back stage: load extract, register file with bypass, WB slot; WB_INSTRET_EN adds instret
module write_back (
  input  logic         clk,
  input  logic         rst,
  write_back_if.slave  wb_if,
  input  logic [4:0]   rs1_addr,
  input  logic [4:0]   rs2_addr,
  output logic [31:0]  rs1_data,
  output logic [31:0]  rs2_data,
  output logic         load_misalign,
  output logic [63:0]  instret
);
  logic        we;
  logic        is_load;
  logic        misalign_now;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] wb;

  logic [31:0] regs_q [31:1];
  logic [31:0] regs_d [31:1];
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regwr_q, regwr_d;
  logic        misalign_q, misalign_d;

  always_comb begin
    we      = wb_if.RegWrite_pype3 & ~wb_if.keep & (wb_if.WReg_pype3 != 5'd0);
    funct3  = wb_if.Instraction_pype3[14:12];
    off     = wb_if.ALU_co_pype3[1:0];
    is_load = (wb_if.MemtoReg_pype3 == 2'b01) & ~wb_if.keep & (wb_if.Instraction_pype3 != 32'd0);

    case (off)
      2'd0:    ld_byte = wb_if.mem_data_pype[7:0];
      2'd1:    ld_byte = wb_if.mem_data_pype[15:8];
      2'd2:    ld_byte = wb_if.mem_data_pype[23:16];
      default: ld_byte = wb_if.mem_data_pype[31:24];
    endcase
    ld_half = off[1] ? wb_if.mem_data_pype[31:16] : wb_if.mem_data_pype[15:0];

    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = wb_if.mem_data_pype;
    endcase

    case (wb_if.MemtoReg_pype3)
      2'b01:   wb = ld_data;
      2'b10:   wb = wb_if.PCp4_pype3;
      default: wb = wb_if.ALU_co_pype3;
    endcase

    // Misaligned data is still written using the lane rules; the flag only records it.
    misalign_now = is_load &
                   ((((funct3 == 3'b001) | (funct3 == 3'b101)) & off[0]) |
                    ((funct3 == 3'b010) & (off != 2'd0)));
  end

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wb_if.WReg_pype3] = wb;
    wb_data_d  = wb_if.keep ? wb_data_q : wb;
    wreg_d     = wb_if.keep ? wreg_q : wb_if.WReg_pype3;
    regwr_d    = we;
    misalign_d = misalign_q | misalign_now;
  end

  // Write-through bypass so decode sees a same-cycle commit.
  always_comb begin
    if (rs1_addr == 5'd0)                          rs1_data = 32'd0;
    else if (we && rs1_addr == wb_if.WReg_pype3)   rs1_data = wb;
    else                                           rs1_data = regs_q[rs1_addr];
    if (rs2_addr == 5'd0)                          rs2_data = 32'd0;
    else if (we && rs2_addr == wb_if.WReg_pype3)   rs2_data = wb;
    else                                           rs2_data = regs_q[rs2_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= 32'd0;
      wb_data_q  <= 32'd0;
      wreg_q     <= 5'd0;
      regwr_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) regs_q[i] <= regs_d[i];
      wb_data_q  <= wb_data_d;
      wreg_q     <= wreg_d;
      regwr_q    <= regwr_d;
      misalign_q <= misalign_d;
    end
  end

  assign wb_if.WB_data_pype4  = wb_data_q;
  assign wb_if.WReg_pype4     = wreg_q;
  assign wb_if.RegWrite_pype4 = regwr_q;
  assign load_misalign        = misalign_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (!wb_if.keep && wb_if.Instraction_pype3 != 32'd0) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instret_q <= 64'd0;
    else      instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = 64'b0;
`endif
endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - scoreboard bench for write_back
module tb_write_back;
  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        load_misalign;
  logic [63:0] instret;

  write_back_if bus ();

  write_back dut (
    .clk          (clk),
    .rst          (rst),
    .wb_if        (bus.slave),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .load_misalign(load_misalign),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q [$];
  logic [63:0] exp_ret;
  logic        pend;

  localparam logic [31:0] I_ALU = 32'h0000_0013;
  localparam logic [31:0] I_LB  = 32'h0000_0003;
  localparam logic [31:0] I_LH  = 32'h0000_1003;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_LBU = 32'h0000_4003;
  localparam logic [31:0] I_LHU = 32'h0000_5003;
  localparam logic [31:0] I_JAL = 32'h0000_006F;
  localparam logic [31:0] MD    = 32'h80FF_7F01;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_instret(input string name);
`ifdef WB_INSTRET_EN
    check(name, instret, exp_ret);
`else
    check(name, instret, 64'd0);
`endif
  endtask

  // Monitor: every WB slot commit must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.RegWrite_pype4 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_slot_unexpected: got reg %0d data 0x%0h expected no commit",
                 bus.WReg_pype4, bus.WB_data_pype4);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.WReg_pype4, bus.WB_data_pype4} !== e) begin
          errors++;
          $display("FAIL wb_slot: got reg %0d data 0x%0h expected reg %0d data 0x%0h",
                   bus.WReg_pype4, bus.WB_data_pype4, e[36:32], e[31:0]);
        end
      end
    end
  end

  // Drive one MEM/WB beat just after the edge; exp_wb is the hand-computed write-back value.
  task automatic issue(input logic rw, input logic [1:0] m2r, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] md,
                       input logic [31:0] instr, input logic kp, input logic [31:0] exp_wb);
    @(posedge clk);
    if (pend) exp_ret = exp_ret + 64'd1;
    #1;
    bus.RegWrite_pype3    = rw;
    bus.MemtoReg_pype3    = m2r;
    bus.WReg_pype3        = wr;
    bus.ALU_co_pype3      = alu;
    bus.PCp4_pype3        = pc;
    bus.mem_data_pype     = md;
    bus.Instraction_pype3 = instr;
    bus.keep              = kp;
    pend = !kp && instr != 32'd0;
    if (rw && !kp && wr != 5'd0) exp_q.push_back({wr, exp_wb});
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    exp_ret = 64'd0;
    pend = 1'b0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    bus.keep = 1'b0;
    bus.RegWrite_pype3 = 1'b0;
    bus.MemtoReg_pype3 = 2'b00;
    bus.WReg_pype3 = 5'd0;
    bus.ALU_co_pype3 = 32'd0;
    bus.PCp4_pype3 = 32'd0;
    bus.mem_data_pype = 32'd0;
    bus.Instraction_pype3 = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    rs1_addr = 5'd5; rs2_addr = 5'd31; #1;
    check("reset_rs1", rs1_data, 32'd0);
    check("reset_rs2", rs2_data, 32'd0);
    check("reset_wb_data", bus.WB_data_pype4, 32'd0);
    check("reset_wreg", bus.WReg_pype4, 5'd0);
    check("reset_regwrite", bus.RegWrite_pype4, 1'b0);
    check("reset_misalign", load_misalign, 1'b0);
    check_instret("reset_instret");

    issue(1'b1, 2'b00, 5'd5, 32'h0000_1234, 32'd0, 32'd0, I_ALU, 1'b0, 32'h0000_1234);
    check("bypass_x5", rs1_data, 32'h0000_1234);

    issue(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, I_ALU, 1'b0, 32'd0);
    rs1_addr = 5'd0; rs2_addr = 5'd5; #1;
    check("x0_reads_zero", rs1_data, 32'd0);
    check("array_x5", rs2_data, 32'h0000_1234);

    issue(1'b1, 2'b01, 5'd6, 32'h0000_0003, 32'd0, MD, I_LB, 1'b0, 32'hFFFF_FF80);
    rs1_addr = 5'd6; #1;
    check("lb_off3_bypass", rs1_data, 32'hFFFF_FF80);
    issue(1'b1, 2'b01, 5'd7, 32'h0000_0003, 32'd0, MD, I_LBU, 1'b0, 32'h0000_0080);
    issue(1'b1, 2'b01, 5'd8, 32'h0000_0002, 32'd0, MD, I_LH, 1'b0, 32'hFFFF_80FF);
    issue(1'b1, 2'b01, 5'd9, 32'h0000_0000, 32'd0, MD, I_LHU, 1'b0, 32'h0000_7F01);
    check("aligned_no_misalign", load_misalign, 1'b0);
    check_instret("instret_after_loads");

    issue(1'b1, 2'b01, 5'd10, 32'h0000_1002, 32'd0, 32'h1122_3344, I_LW, 1'b0, 32'h1122_3344);
    rs1_addr = 5'd11; rs2_addr = 5'd11;
    issue(1'b1, 2'b01, 5'd11, 32'h0000_1000, 32'd0, 32'hCAFE_BABE, I_LW, 1'b0, 32'hCAFE_BABE);
    check("misalign_set", load_misalign, 1'b1);
    check("dual_bypass_rs1", rs1_data, 32'hCAFE_BABE);
    check("dual_bypass_rs2", rs2_data, 32'hCAFE_BABE);

    rs1_addr = 5'd12;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 2'b10, 5'd12, 32'h0000_DEAD, 32'h0000_0104, 32'd0, I_JAL, 1'b1, 32'h0000_0104);
      check("keep_no_write", rs1_data, 32'd0);
    end
    issue(1'b1, 2'b10, 5'd12, 32'h0000_DEAD, 32'h0000_0104, 32'd0, I_JAL, 1'b0, 32'h0000_0104);
    check("keep_release_bypass", rs1_data, 32'h0000_0104);
    check("misalign_sticky", load_misalign, 1'b1);

    for (int i = 0; i < 4; i++) idle();
    check_instret("instret_after_bubbles");
    rs1_addr = 5'd7; rs2_addr = 5'd8; #1;
    check("array_x7_lbu", rs1_data, 32'h0000_0080);
    check("array_x8_lh", rs2_data, 32'hFFFF_80FF);
    rs1_addr = 5'd9; rs2_addr = 5'd10; #1;
    check("array_x9_lhu", rs1_data, 32'h0000_7F01);
    check("array_x10_lw", rs2_data, 32'h1122_3344);
    rs1_addr = 5'd12; rs2_addr = 5'd6; #1;
    check("array_x12_pc4", rs1_data, 32'h0000_0104);
    check("array_x6_lb", rs2_data, 32'hFFFF_FF80);

    // Reset lands before the edge that would commit x13; that write must be lost.
    issue(1'b1, 2'b00, 5'd13, 32'h0000_0055, 32'd0, 32'd0, I_ALU, 1'b0, 32'h0000_0055);
    void'(exp_q.pop_back());
    #1 rst = 1'b0;
    pend = 1'b0;
    exp_ret = 64'd0;
    @(posedge clk);
    #1;
    bus.RegWrite_pype3 = 1'b0;
    bus.Instraction_pype3 = 32'd0;
    rst = 1'b1;
    rs1_addr = 5'd13; rs2_addr = 5'd5; #1;
    check("reset_discards_x13", rs1_data, 32'd0);
    check("reset_clears_x5", rs2_data, 32'd0);
    check("reset_clears_misalign", load_misalign, 1'b0);
    check_instret("reset_clears_instret");

    idle();
    idle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish before 50000");
    $fatal(1);
  end
endmodule
